// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and helpers.
// Used by the message padder and the hash core.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int    BLOCK_WORDS = 16;
  localparam word_t PAD_MARKER  = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PAD,
    S_DRAIN
  } state_e;

  typedef struct packed {
    word_t      data;
    logic [3:0] idx;
    logic       block_last;
    logic       msg_last;
  } fifo_entry_t;

  // ceil((n + 3) / 16): marker word plus two length words
  function automatic logic [31:0] num_blocks(input logic [31:0] n);
    return (n + 32'd18) >> 4;
  endfunction

  function automatic word_t rightrotate(
    input word_t      x,
    input logic [4:0] n
  );
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Padded word stream towards the hash core.
// Master drives the word, slave drives ready.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  logic       out_valid;
  logic       out_ready;
  word_t      out_data;
  logic [3:0] out_idx;
  logic       out_block_last;
  logic       out_msg_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_block_last,
    output out_msg_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_block_last,
    input  out_msg_last,
    output out_ready
  );

endinterface

// File: rtl/sha256_word_fifo.sv
// Small synchronous FIFO of padded words with tags.
// Head entry is presented combinationally.
module sha256_word_fifo
  import sha256_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  fifo_entry_t   entry_i,
  input  logic          pop_i,
  output fifo_entry_t   entry_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q < DEPTH_C) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= entry_i;
        wr_q        <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign entry_o = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads a message from word memory and streams it
// SHA-256 padded, one 32-bit word per cycle.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] msg_words,
  output logic              busy,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  word_t             mem_read_data,
  sha256_msg_padder_if.master stream
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       n_q, n_d;
  logic [31:0]       total_q, total_d;
  logic [31:0]       rd_k_q, rd_k_d;
  logic [31:0]       enq_k_q, enq_k_d;
  logic              inflight_q;

  logic              rd_issue;
  logic              gen_push;
  logic              push;
  logic              pop;
  logic              room_rd;
  logic              room_gen;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [31:0]       occ;
  logic [31:0]       lim;
  logic [63:0]       bit_len;
  word_t             gen_word;
  fifo_entry_t       enq_e;
  fifo_entry_t       head_e;

  assign pop      = stream.out_valid && stream.out_ready;
  assign occ      = 32'(fifo_cnt);
  assign lim      = 32'(FIFO_DEPTH) + 32'(pop);
  assign room_rd  = (occ + 32'(inflight_q)) < lim;
  assign room_gen = occ < lim;

  // generated words wait for the last read to land
  assign gen_push = (state_q == S_PAD) && !inflight_q && room_gen;
  assign push     = inflight_q || gen_push;
  assign bit_len  = 64'(n_q) << 5;

  always_comb begin
    gen_word = '0;
    unique case (1'b1)
      (enq_k_q == n_q):             gen_word = PAD_MARKER;
      (enq_k_q == total_q - 32'd2): gen_word = bit_len[63:32];
      (enq_k_q == total_q - 32'd1): gen_word = bit_len[31:0];
      default:                      gen_word = '0;
    endcase
  end

  always_comb begin
    enq_e            = '0;
    enq_e.data       = inflight_q ? mem_read_data : gen_word;
    enq_e.idx        = enq_k_q[3:0];
    enq_e.block_last = &enq_k_q[3:0];
    enq_e.msg_last   = (enq_k_q == total_q - 32'd1);
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    n_d      = n_q;
    total_d  = total_q;
    rd_k_d   = rd_k_q;
    enq_k_d  = enq_k_q;
    rd_issue = 1'b0;
    mem_addr = '0;
    if (push) begin
      enq_k_d = enq_k_q + 32'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start && !reset) begin
          base_d  = message_addr;
          n_d     = 32'(msg_words);
          total_d = num_blocks(32'(msg_words)) << 4;
          rd_k_d  = '0;
          enq_k_d = '0;
          if (msg_words == '0) begin
            state_d = S_PAD;
          end else begin
            // word 0 is read right away to reach 2-cycle latency
            rd_issue = 1'b1;
            mem_addr = message_addr;
            rd_k_d   = 32'd1;
            state_d  = (msg_words == ADDR_W'(1)) ? S_PAD : S_FETCH;
          end
        end
      end
      S_FETCH: begin
        mem_addr = base_q + rd_k_q[ADDR_W-1:0];
        if (room_rd) begin
          rd_issue = 1'b1;
          rd_k_d   = rd_k_q + 32'd1;
          if (rd_k_d == n_q) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        mem_addr = base_q + rd_k_q[ADDR_W-1:0];
        if (gen_push && (enq_k_q == total_q - 32'd1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        mem_addr = base_q + rd_k_q[ADDR_W-1:0];
        if (fifo_cnt == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      n_q        <= '0;
      total_q    <= '0;
      rd_k_q     <= '0;
      enq_k_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      n_q        <= n_d;
      total_q    <= total_d;
      rd_k_q     <= rd_k_d;
      enq_k_q    <= enq_k_d;
      inflight_q <= rd_issue;
    end
  end

  sha256_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CNT_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .entry_i (enq_e),
    .pop_i   (pop),
    .entry_o (head_e),
    .count_o (fifo_cnt)
  );

  assign stream.out_valid      = (fifo_cnt != '0);
  assign stream.out_data       = head_e.data;
  assign stream.out_idx        = head_e.idx;
  assign stream.out_block_last = head_e.block_last;
  assign stream.out_msg_last   = head_e.msg_last;

  // DRAIN with an empty FIFO is the cycle after the final handshake
  assign done    = (state_q == S_DRAIN) && (fifo_cnt == '0);
  assign busy    = (state_q != S_IDLE) && !done;
  assign mem_clk = clk;
  assign mem_we  = 1'b0;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder.
// Memory returns {16'hC0DE, address} for every word.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] message_addr = '0;
  logic [15:0] msg_words = '0;
  logic        busy;
  logic        done;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data = '0;

  sha256_msg_padder_if sif();

  sha256_msg_padder #(.ADDR_W(16), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .message_addr  (message_addr),
    .msg_words     (msg_words),
    .busy          (busy),
    .done          (done),
    .mem_clk       (mem_clk),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_read_data (mem_read_data),
    .stream        (sif.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_read_data <= {16'hC0DE, mem_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_data[$];
  logic [3:0]  got_idx[$];
  logic        got_bl[$];
  logic        got_ml[$];
  int          got_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          mpops = 0;
  int          stall_err = 0;
  int          over_err = 0;
  logic        prev_stall = 1'b0;
  logic [37:0] prev_snap = '0;
  logic [15:0] adiff;

  logic [15:0] cur_base = '0;
  int          pop0 = 0;
  int          q0, d0, s0, o0, scyc;
  bit          tmo;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) begin
        adiff = mem_addr - cur_base;
        if (int'(adiff) > mpops - pop0 + 2) over_err++;
      end
      if (prev_stall && ({sif.out_valid, sif.out_data, sif.out_idx,
          sif.out_block_last, sif.out_msg_last} != {1'b1, prev_snap}))
        stall_err++;
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_snap = {sif.out_data, sif.out_idx,
                   sif.out_block_last, sif.out_msg_last};
      if (sif.out_valid && sif.out_ready) begin
        got_data.push_back(sif.out_data);
        got_idx.push_back(sif.out_idx);
        got_bl.push_back(sif.out_block_last);
        got_ml.push_back(sif.out_msg_last);
        got_cyc.push_back(cyc);
        mpops++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [31:0] exp_word(
    input logic [15:0] base, input int n, input int k);
    int t;
    logic [15:0] a;
    t = ((n + 18) / 16) * 16;
    a = base + 16'(k);
    if (k < n) return {16'hC0DE, a};
    if (k == n) return 32'h8000_0000;
    if (k == t - 1) return 32'(n * 32);
    return 32'h0;
  endfunction

  task automatic snap();
    cur_base = message_addr;
    pop0 = mpops;
    q0 = got_data.size();
    d0 = done_cnt;
    s0 = stall_err;
    o0 = over_err;
  endtask

  task automatic run_msg(input logic [15:0] base, input logic [15:0] n,
                         input bit rnd, input int xstart, input bit sod);
    tmo = 1'b1;
    @(posedge clk); #1;
    message_addr = base;
    msg_words = n;
    snap();
    start = 1'b1;
    sif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    scyc = cyc;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      message_addr = 16'hDEAD;
      msg_words = 16'd5;
      if (i == xstart) begin
        start = 1'b1;
        message_addr = 16'h0700;
      end
      if (sod && done) begin
        start = 1'b1;
        message_addr = 16'h0900;
        msg_words = 16'd4;
      end
      sif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done_cnt != d0) begin
        tmo = 1'b0;
        break;
      end
    end
    start = 1'b0;
    sif.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", sif.out_valid); end
    checks++; if (sif.out_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", sif.out_data); end
    checks++; if (sif.out_idx !== 4'h0) begin failures++; $display("FAIL rst_idx got=%h exp=0", sif.out_idx); end
    checks++; if ({sif.out_block_last, sif.out_msg_last} !== 2'b00) begin failures++; $display("FAIL rst_last got=%b%b exp=00", sif.out_block_last, sif.out_msg_last); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", mem_we); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_n20();
    run_msg(16'h0100, 16'd20, 1'b0, -1, 1'b0);
    checks++; if (tmo) begin failures++; $display("FAIL n20_timeout got=no_done exp=done"); end
    checks++; if (got_data.size() - q0 != 32) begin failures++; $display("FAIL n20_count got=%0d exp=32", got_data.size() - q0); end
    if (got_data.size() - q0 >= 32) begin
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (got_data[q0+k] !== exp_word(16'h0100, 20, k) || got_idx[q0+k] !== 4'(k)
            || got_bl[q0+k] !== (k % 16 == 15) || got_ml[q0+k] !== (k == 31)) begin
          failures++;
          $display("FAIL n20_word k=%0d got=%h/%0d/%b%b exp=%h/%0d/%b%b", k, got_data[q0+k],
                   got_idx[q0+k], got_bl[q0+k], got_ml[q0+k], exp_word(16'h0100, 20, k),
                   k % 16, k % 16 == 15, k == 31);
        end
      end
      checks++; if (got_data[q0+20] !== 32'h8000_0000) begin failures++; $display("FAIL n20_marker got=%h exp=80000000", got_data[q0+20]); end
      checks++; if (got_data[q0+31] !== 32'h0000_0280) begin failures++; $display("FAIL n20_len got=%h exp=00000280", got_data[q0+31]); end
      checks++; if (got_cyc[q0] !== scyc + 2) begin failures++; $display("FAIL n20_latency got=%0d exp=%0d", got_cyc[q0] - scyc, 2); end
      checks++; if (got_cyc[q0+31] - got_cyc[q0] !== 31) begin failures++; $display("FAIL n20_bubbles got=%0d exp=31", got_cyc[q0+31] - got_cyc[q0]); end
      checks++; if (done_cyc !== got_cyc[q0+31] + 1) begin failures++; $display("FAIL n20_done_cycle got=%0d exp=%0d", done_cyc, got_cyc[q0+31] + 1); end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL n20_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_n13();
    run_msg(16'h0040, 16'd13, 1'b0, -1, 1'b0);
    checks++; if (tmo) begin failures++; $display("FAIL n13_timeout got=no_done exp=done"); end
    checks++; if (got_data.size() - q0 != 16) begin failures++; $display("FAIL n13_count got=%0d exp=16", got_data.size() - q0); end
    if (got_data.size() - q0 >= 16) begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (got_data[q0+k] !== exp_word(16'h0040, 13, k) || got_ml[q0+k] !== (k == 15)) begin
          failures++;
          $display("FAIL n13_word k=%0d got=%h/%b exp=%h/%b", k, got_data[q0+k], got_ml[q0+k],
                   exp_word(16'h0040, 13, k), k == 15);
        end
      end
      checks++; if (got_data[q0+13] !== 32'h8000_0000) begin failures++; $display("FAIL n13_marker got=%h exp=80000000", got_data[q0+13]); end
      checks++; if (got_data[q0+14] !== 32'h0) begin failures++; $display("FAIL n13_hi got=%h exp=0", got_data[q0+14]); end
      checks++; if (got_data[q0+15] !== 32'h0000_01A0) begin failures++; $display("FAIL n13_len got=%h exp=000001a0", got_data[q0+15]); end
      checks++; if (got_bl[q0+15] !== 1'b1) begin failures++; $display("FAIL n13_blast got=%b exp=1", got_bl[q0+15]); end
    end
  endtask

  task automatic test_n14_n0();
    // base near the top of memory exercises address wrap
    run_msg(16'hFFF8, 16'd14, 1'b0, -1, 1'b0);
    checks++; if (tmo) begin failures++; $display("FAIL n14_timeout got=no_done exp=done"); end
    checks++; if (got_data.size() - q0 != 32) begin failures++; $display("FAIL n14_count got=%0d exp=32", got_data.size() - q0); end
    if (got_data.size() - q0 >= 32) begin
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (got_data[q0+k] !== exp_word(16'hFFF8, 14, k) || got_ml[q0+k] !== (k == 31)) begin
          failures++;
          $display("FAIL n14_word k=%0d got=%h exp=%h", k, got_data[q0+k], exp_word(16'hFFF8, 14, k));
        end
      end
      checks++; if (got_data[q0+9] !== 32'hC0DE_0001) begin failures++; $display("FAIL n14_wrap got=%h exp=c0de0001", got_data[q0+9]); end
      checks++; if (got_data[q0+14] !== 32'h8000_0000) begin failures++; $display("FAIL n14_marker got=%h exp=80000000", got_data[q0+14]); end
      checks++; if (got_data[q0+15] !== 32'h0) begin failures++; $display("FAIL n14_w15 got=%h exp=0", got_data[q0+15]); end
      checks++; if (got_data[q0+31] !== 32'h0000_01C0) begin failures++; $display("FAIL n14_len got=%h exp=000001c0", got_data[q0+31]); end
    end
    run_msg(16'h0500, 16'd0, 1'b0, -1, 1'b0);
    checks++; if (tmo) begin failures++; $display("FAIL n0_timeout got=no_done exp=done"); end
    checks++; if (got_data.size() - q0 != 16) begin failures++; $display("FAIL n0_count got=%0d exp=16", got_data.size() - q0); end
    if (got_data.size() - q0 >= 16) begin
      checks++; if (got_data[q0] !== 32'h8000_0000) begin failures++; $display("FAIL n0_marker got=%h exp=80000000", got_data[q0]); end
      for (int k = 1; k < 16; k++) begin
        checks++;
        if (got_data[q0+k] !== 32'h0 || got_ml[q0+k] !== (k == 15)) begin
          failures++;
          $display("FAIL n0_word k=%0d got=%h/%b exp=0/%b", k, got_data[q0+k], got_ml[q0+k], k == 15);
        end
      end
      checks++; if (got_cyc[q0] !== scyc + 2) begin failures++; $display("FAIL n0_latency got=%0d exp=2", got_cyc[q0] - scyc); end
    end
  endtask

  task automatic test_random_ready();
    run_msg(16'h0100, 16'd20, 1'b1, -1, 1'b0);
    checks++; if (tmo) begin failures++; $display("FAIL rnd_timeout got=no_done exp=done"); end
    checks++; if (got_data.size() - q0 != 32) begin failures++; $display("FAIL rnd_count got=%0d exp=32", got_data.size() - q0); end
    if (got_data.size() - q0 >= 32) begin
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (got_data[q0+k] !== exp_word(16'h0100, 20, k) || got_idx[q0+k] !== 4'(k)
            || got_bl[q0+k] !== (k % 16 == 15) || got_ml[q0+k] !== (k == 31)) begin
          failures++;
          $display("FAIL rnd_word k=%0d got=%h exp=%h", k, got_data[q0+k], exp_word(16'h0100, 20, k));
        end
      end
    end
    checks++; if (stall_err - s0 != 0) begin failures++; $display("FAIL rnd_stable got=%0d exp=0", stall_err - s0); end
    checks++; if (over_err - o0 != 0) begin failures++; $display("FAIL rnd_overread got=%0d exp=0", over_err - o0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL rnd_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    @(posedge clk); #1;
    message_addr = 16'h0100;
    msg_words = 16'd20;
    snap();
    start = 1'b1;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (got_data.size() - q0 >= 10) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL mid_reach got=no_word9 exp=word9"); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", sif.out_valid); end
    run_msg(16'h0200, 16'd13, 1'b0, -1, 1'b0);
    checks++; if (tmo) begin failures++; $display("FAIL mid_timeout got=no_done exp=done"); end
    checks++; if (got_data.size() - q0 != 16) begin failures++; $display("FAIL mid_count got=%0d exp=16", got_data.size() - q0); end
    if (got_data.size() - q0 >= 16) begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (got_data[q0+k] !== exp_word(16'h0200, 13, k) || got_idx[q0+k] !== 4'(k)) begin
          failures++;
          $display("FAIL mid_word k=%0d got=%h/%0d exp=%h/%0d", k, got_data[q0+k], got_idx[q0+k],
                   exp_word(16'h0200, 13, k), k);
        end
      end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL mid_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_start_during_busy();
    run_msg(16'h0300, 16'd20, 1'b0, 5, 1'b1);
    checks++; if (tmo) begin failures++; $display("FAIL busy_timeout got=no_done exp=done"); end
    checks++; if (got_data.size() - q0 != 32) begin failures++; $display("FAIL busy_count got=%0d exp=32", got_data.size() - q0); end
    if (got_data.size() - q0 >= 32) begin
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (got_data[q0+k] !== exp_word(16'h0300, 20, k)) begin
          failures++;
          $display("FAIL busy_word k=%0d got=%h exp=%h", k, got_data[q0+k], exp_word(16'h0300, 20, k));
        end
      end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt - d0); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle got=%b exp=0", busy); end
  endtask

  initial begin
    sif.out_ready = 1'b1;
    test_reset();
    test_n20();
    test_n13();
    test_n14_n0();
    test_random_ready();
    test_reset_mid();
    test_start_during_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
